seq_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider. It is the inverse companion of the combinational

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared state encoding and default width for the sequential divider.
// Revision: 1.0
// ============================================================================
package div_pkg;

    localparam int DIV_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One restoring-division iteration: shift, compare, conditional subtract.
// Revision: 1.0
// ============================================================================
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dq,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] dq_nxt
);

    logic [WIDTH:0] w_rs;
    logic           w_ge;

    always_comb begin
        w_rs = {rem, dq[WIDTH-1]};
        w_ge = (w_rs >= {1'b0, div});
        // When w_ge holds, rs < 2*div, so the difference always fits in WIDTH bits
        rem_nxt = w_ge ? WIDTH'(w_rs - {1'b0, div}) : w_rs[WIDTH-1:0];
        dq_nxt  = (dq << 1) | WIDTH'(w_ge);
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Brief   : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] dq_q,       dq_d;
    logic [WIDTH-1:0] div_q,      div_d;
    logic [WIDTH-1:0] q_q,        q_d;
    logic [WIDTH-1:0] r_q,        r_d;
    logic             div_zero_q, div_zero_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dq_nxt;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem     (rem_q),
        .dq      (dq_q),
        .div     (div_q),
        .rem_nxt (w_rem_nxt),
        .dq_nxt  (w_dq_nxt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dq_d       = dq_q;
        div_d      = div_q;
        q_d        = q_q;
        r_d        = r_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dq_d  = A;
                    div_d = B;
                    rem_d = '0;
                    cnt_d = CNT_W'(WIDTH);
                    // Zero divisor resolves immediately with the conventional result
                    if (B == '0) begin
                        state_d    = S_DONE;
                        q_d        = '1;
                        r_d        = A;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                rem_d = w_rem_nxt;
                dq_d  = w_dq_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    q_d        = w_dq_nxt;
                    r_d        = w_rem_nxt;
                    div_zero_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dq_q       <= '0;
            div_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dq_q       <= dq_d;
            div_q      <= div_d;
            q_q        <= q_d;
            r_q        <= r_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = div_zero_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_divider
// Brief   : Self-checking bench for seq_divider against an arithmetic reference.
// Revision: 1.0
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_zero;

    int checks;
    int errors;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_r;
    logic             prev_dz;

    seq_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one operation starting from IDLE or DONE; returns in the DONE cycle.
    task automatic run_op(input int a, input int b, input bit inject);
        int n;
        int busy_cnt;
        int exp_q;
        int exp_r;
        int exp_dz;
        if (b == 0) begin
            exp_q  = (1 << WIDTH) - 1;
            exp_r  = a;
            exp_dz = 1;
        end else begin
            exp_q  = a / b;
            exp_r  = a % b;
            exp_dz = 0;
        end
        start = 1'b1;
        A     = WIDTH'(a);
        B     = WIDTH'(b);
        @(posedge clk); #1;
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 12) begin
            if (busy) busy_cnt++;
            chk("hold_q", 32'(Q), 32'(prev_q));
            chk("hold_r", 32'(R), 32'(prev_r));
            chk("hold_dz", 32'(div_zero), 32'(prev_dz));
            if (inject && n == 1) begin
                start = 1'b1;
                A     = 4'd1;
                B     = 4'd1;
            end else if (inject && n == 2) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", 32'(n), (b == 0) ? 32'd0 : 32'(WIDTH));
        chk("busy_cycles", 32'(busy_cnt), (b == 0) ? 32'd0 : 32'(WIDTH));
        chk("done", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("q", 32'(Q), 32'(exp_q));
        chk("r", 32'(R), 32'(exp_r));
        chk("div_zero", 32'(div_zero), 32'(exp_dz));
        prev_q  = WIDTH'(exp_q);
        prev_r  = WIDTH'(exp_r);
        prev_dz = exp_dz[0];
    endtask

    task automatic idle_tick();
        @(posedge clk); #1;
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_op(15, 3, 1'b0);
        idle_tick();
        run_op(13, 4, 1'b0);
        run_op(3, 9, 1'b0);
        idle_tick();
        run_op(7, 0, 1'b0);
        idle_tick();
        run_op(15, 3, 1'b1);
        idle_tick();

        // Reset in the middle of a calculation
        start = 1'b1;
        A     = 4'd14;
        B     = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(Q), 32'd0);
        chk("abort_r", 32'(R), 32'd0);
        chk("abort_dz", 32'(div_zero), 32'd0);
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_no_busy", 32'(busy), 32'd0);
        end
        run_op(14, 2, 1'b0);
        idle_tick();

        // Sweep of every non-zero divisor, issued back to back
        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 1; b < (1 << WIDTH); b++) begin
                run_op(a, b, 1'b0);
                chk("sweep_qb_plus_r", 32'(int'(Q) * b + int'(R)), 32'(a));
                chk("sweep_r_lt_b", 32'(int'(R) < b), 32'd1);
            end
        end
        idle_tick();

        // Randomized mix including zero divisors and idle gaps
        repeat (150) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, (1 << WIDTH) - 1));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << WIDTH) - 1));
            run_op(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
